// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller (serial_add_ctrl).
// The optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam state_e STATE_RESET = ST_IDLE;

endpackage

// File: rtl/serial_add_bit.sv
// One-bit full-adder slice: two half-adder stages joined by an OR of their carries.
module serial_add_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p_s;
    logic g1_s;
    logic g2_s;

    // first half adder on the operand bits, second folds in the carry
    always_comb begin
        p_s  = a ^ b;
        g1_s = a & b;
        s    = p_s ^ cin;
        g2_s = p_s & cin;
        cout = g1_s | g2_s;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared adder slice processes WIDTH bits LSB first.
// Defining SERIAL_ADD_SUB_EN adds the sub port and two's-complement subtraction.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;

    logic             sub_s;
    logic             bit_s;
    logic             cout_s;
    logic             last_s;
    logic [WIDTH-1:0] sum_next_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    serial_add_bit u_bit (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .s    (bit_s),
        .cout (cout_s)
    );

    // next values of the shift registers; the new result bit enters at the MSB
    always_comb begin
        a_next_s              = a_sh_r >> 1;
        b_next_s              = b_sh_r >> 1;
        sum_next_s            = sum >> 1;
        sum_next_s[WIDTH-1]   = bit_s;
        last_s                = (cnt_r == CNT_LAST);
    end

    // control FSM, operand/result shifters, bit counter and carry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= STATE_RESET;
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            carry_r   <= 1'b0;
            cnt_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // subtraction is a + ~b + 1: invert b and seed the carry
                        a_sh_r  <= a;
                        b_sh_r  <= sub_s ? ~b : b;
                        carry_r <= sub_s;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_r  <= a_next_s;
                    b_sh_r  <= b_next_s;
                    sum     <= sum_next_s;
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        carry_out <= cout_s;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= STATE_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl; subtract cases run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = 1'b0;
    logic [0:0]   b1 = 1'b0;
    logic         busy1, done1, cout1;
    logic [0:0]   sum1;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub_in),
`endif
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef SERIAL_ADD_SUB_EN
        .sub(1'b0),
`endif
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
        logic [W:0] one;
        one = {{W{1'b0}}, 1'b1};
        if (s) return {1'b0, x} + {1'b0, ~y} + one;
        else   return {1'b0, x} + {1'b0, y};
    endfunction

    // Model: m_age counts edges since the accepted start (-1 = never started since reset).
    int           m_age = -1;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age  <= -1;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if ((m_age < 0 || m_age >= W + 1) && start) begin
            m_age <= 0;
            {m_cout, m_sum} <= model_result(a, b, sub_in);
        end else if (m_age >= 0 && m_age < 1000) begin
            m_age <= m_age + 1;
        end else begin
            m_age <= m_age;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_age >= 0 && m_age < W));
        check("done", 32'(done), 32'(m_age == W));
        if (m_age < 0 || m_age >= W) begin
            check("sum", 32'(sum), 32'(m_sum));
            check("carry_out", 32'(carry_out), 32'(m_cout));
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [W-1:0] es, input logic ec);
        int n = 0;
        int nb = 0;
        bit seen = 1'b0;
        @(posedge clk); #2;
        a = x; b = y; sub_in = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(W + 1));
        check("busy_cycles", 32'(nb), 32'(W));
        check("op_sum", 32'(sum), 32'(es));
        check("op_cout", 32'(carry_out), 32'(ec));
        check("model_sum", 32'(m_sum), 32'(es));
        check("model_cout", 32'(m_cout), 32'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] x, y, es;
        logic [W:0]   t;
        logic         s, ec;
        int           dn, n, nb;
        bit           seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

        // start held high; operands scrambled while busy must not leak into results
        @(posedge clk); #2;
        a = 8'h12; b = 8'h34; start = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (m_age >= 0 && m_age < W) begin
                a = W'($urandom); b = W'($urandom);
            end else begin
                a = 8'h12; b = 8'h34;
            end
            @(negedge clk);
            if (done) begin
                dn++;
                check("held_sum", 32'(sum), 32'h46);
            end
        end
        check("held_done_count", 32'(dn), 32'd4);
        start = 1'b0;
        repeat (12) @(posedge clk);

        // reset during the 4th RUN cycle
        #2;
        a = W'($urandom); b = W'($urandom); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(carry_out), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`endif

        for (int i = 0; i < 16; i++) begin
            x = W'($urandom);
            y = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            if (s) begin
                es = x - y;
                ec = (x >= y);
            end else begin
                t  = {1'b0, x} + {1'b0, y};
                es = t[W-1:0];
                ec = t[W];
            end
            run_op(x, y, s, es, ec);
        end

        // free-running random start/operand traffic, checked every cycle by the model
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            start = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub_in = 1'($urandom);
`endif
        end
        start = 1'b0;
        repeat (12) @(posedge clk);

        // WIDTH=1 instance
        #2;
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        n = 0; nb = 0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n++;
            if (busy1) nb++;
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
        check("w1_done_seen", 32'(seen), 32'd1);
        check("w1_latency", 32'(n), 32'd2);
        check("w1_busy_cycles", 32'(nb), 32'd1);
        check("w1_sum", 32'(sum1), 32'd0);
        check("w1_cout", 32'(cout1), 32'd1);
        @(negedge clk);
        check("w1_idle_done", 32'(done1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
